// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the kfpga configuration chain loader:
// FSM state encoding and the counter-width helper.
package kfpga_config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of a down-counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/config_piso.sv
// Parallel-in/serial-out register; bit 0 leaves first, shifting right.
module config_piso #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  bit0
);

  logic [DATA_WIDTH-1:0] sreg_q;

  // Datapath register: contents are don't-care until loaded, so no reset.
  always_ff @(posedge clock) begin
    if (load) begin
      sreg_q <= data_in;
    end else if (shift) begin
      sreg_q <= {1'b0, sreg_q[DATA_WIDTH-1:1]};
    end
  end

  assign bit0 = sreg_q[0];

endmodule

// File: rtl/config_chain_loader.sv
// Loads CHAIN_LENGTH configuration bits LSB-first into a tile's shift chain
// from a valid/ready word stream, then holds done until the next start.
module config_chain_loader
  import kfpga_config_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = cnt_w(CHAIN_LENGTH);
  localparam int WW = cnt_w(DATA_WIDTH);

  state_e          state_q, state_d;
  logic [BW-1:0]   bits_left_q, bits_left_d;
  logic [WW-1:0]   word_left_q, word_left_d;
  logic            piso_load;
  logic            piso_shift;
  logic            piso_bit0;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      word_left_q <= '0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      word_left_q <= word_left_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    word_left_d = word_left_q;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          bits_left_d = BW'(CHAIN_LENGTH);
          word_left_d = '0;
        end
      end
      ST_LOAD: begin
        if (data_valid) begin
          piso_load   = 1'b1;
          // The final word may carry fewer useful bits than DATA_WIDTH.
          word_left_d = (int'(bits_left_q) >= DATA_WIDTH) ? WW'(DATA_WIDTH)
                                                          : WW'(bits_left_q);
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        piso_shift = 1'b1;
        if (bits_left_q != '0) bits_left_d = bits_left_q - BW'(1);
        if (word_left_q != '0) word_left_d = word_left_q - WW'(1);
        if (word_left_q <= WW'(1)) begin
          state_d = (bits_left_q <= BW'(1)) ? ST_DONE : ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  config_piso #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_piso (
    .clock   (clock),
    .load    (piso_load),
    .shift   (piso_shift),
    .data_in (data_in),
    .bit0    (piso_bit0)
  );

  // Every output is a decode of registered state; none sees an input directly.
  assign data_ready    = (state_q == ST_LOAD);
  assign config_enable = (state_q == ST_SHIFT);
  assign config_out    = config_enable & piso_bit0;
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader (CHAIN_LENGTH=34, DATA_WIDTH=8)
// with a bit-level scoreboard filled as words are offered.
module tb_config_chain_loader;

  localparam int DW = 8;
  localparam int CL = 34;

  logic          clock = 1'b0;
  logic          nreset;
  logic          start;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          config_out;
  logic          config_enable;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int bits_rem = 0;
  bit exp_q[$];

  logic [DW-1:0] words [5];

  config_chain_loader #(
    .DATA_WIDTH   (DW),
    .CHAIN_LENGTH (CL)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .start         (start),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .config_out    (config_out),
    .config_enable (config_enable),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (config_enable === 1'b1) begin
      en_cnt++;
      chk("bit_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("config_out", config_out, exp_q.pop_front());
      chk("ready_in_shift", data_ready, 0);
    end else begin
      chk("out_gated", config_out, 0);
    end
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},  data_ready,    0);
    chk({tag, "_out"},    config_out,    0);
    chk({tag, "_enable"}, config_enable, 0);
    chk({tag, "_busy"},   busy,          0);
    chk({tag, "_done"},   done,          0);
  endtask

  task automatic do_start();
    exp_q.delete();
    en_cnt   = 0;
    bits_rem = CL;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy",  busy,       1);
    chk("start_ready", data_ready, 1);
    chk("start_done",  done,       0);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap);
    int n = 0;
    while (data_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("ready_timeout", data_ready, 1);
    repeat (gap) begin
      step();
      chk("gap_enable", config_enable, 0);
      chk("gap_ready",  data_ready,    1);
    end
    data_in    = w;
    data_valid = 1'b1;
    for (int i = 0; i < DW && bits_rem > 0; i++) begin
      exp_q.push_back(w[i]);
      bits_rem--;
    end
    step();
    data_valid = 1'b0;
    data_in    = DW'($urandom);
    chk("first_bit_enable", config_enable, 1);
  endtask

  task automatic wait_en(input int target);
    int n = 0;
    while (en_cnt < target && n < 100) begin
      step();
      n++;
    end
    chk("wait_en", en_cnt >= target, 1);
  endtask

  task automatic wait_done();
    wait_en(CL);
    step();
    chk("done_set",     done,          1);
    chk("done_busy",    busy,          0);
    chk("done_ready",   data_ready,    0);
    chk("done_enable",  config_enable, 0);
    chk("queue_empty",  exp_q.size(),  0);
    repeat (3) step();
    chk("enable_count", en_cnt, CL);
    chk("done_held",    done,   1);
  endtask

  initial begin
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hFF;
    words[3] = 8'h00;
    words[4] = 8'h02;

    // Reset held with active-looking inputs
    nreset     = 1'b0;
    start      = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'hFF;
    repeat (3) step();
    check_all_zero("reset");
    start      = 1'b0;
    data_valid = 1'b0;
    nreset     = 1'b1;
    step();
    check_all_zero("idle_after_reset");

    // Nominal back-to-back load
    do_start();
    for (int i = 0; i < 5; i++) send_word(words[i], 0);
    wait_done();

    // Word offered in DONE is refused, then reload with a starved source
    data_in    = 8'h55;
    data_valid = 1'b1;
    repeat (2) begin
      step();
      chk("done_refuse_ready", data_ready,    0);
      chk("done_refuse_en",    config_enable, 0);
    end
    data_valid = 1'b0;
    do_start();
    for (int i = 0; i < 5; i++) send_word(words[i], 3);
    wait_done();

    // Start pulse while busy is ignored
    do_start();
    send_word(words[0], 0);
    send_word(words[1], 0);
    wait_en(10);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_busy", busy, 1);
    chk("busy_start_done", done, 0);
    for (int i = 2; i < 5; i++) send_word(words[i], 0);
    wait_done();

    // Reset mid-shift, then a fresh full load with random words
    do_start();
    send_word(words[0], 0);
    send_word(words[1], 0);
    wait_en(10);
    nreset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    nreset = 1'b1;
    exp_q.delete();
    step();
    check_all_zero("post_reset_idle");
    do_start();
    for (int i = 0; i < 5; i++) send_word(DW'($urandom), i % 2);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
